// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: odd-parity UART frame receiver with start-glitch rejection, break lockout and ack handshake
module uart_rx_deframer #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rxd,
  input  logic       notify,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       parity_error,
  output logic       frame_error,
  output logic       overrun
);
  localparam int HALF = (CLKS_PER_BIT - 1) / 2;
  localparam int W = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] RELOAD = W'(CLKS_PER_BIT - 1);
  localparam logic [W-1:0] HALF_M1 = W'(HALF > 0 ? HALF - 1 : 0);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state;
  logic rxd_m, rxd_s, notify_m, notify_s, notify_d, ack, armed, par, sample;
  logic [W-1:0] cnt;
  logic [2:0] idx;
  logic [7:0] shift;
  assign sample = cnt == '0;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      rxd_m <= 1'b0;
      rxd_s <= 1'b0;
      notify_m <= 1'b0;
      notify_s <= 1'b0;
      notify_d <= 1'b0;
      ack <= 1'b0;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
      notify_m <= notify;
      notify_s <= notify_m;
      notify_d <= notify_s;
      ack <= notify_s & ~notify_d;
    end
  // completion assignments sit after the ack clear so a coincident frame wins
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      armed <= 1'b0;
      cnt <= '0;
      idx <= '0;
      shift <= '0;
      par <= 1'b0;
      data_out <= '0;
      valid <= 1'b0;
      parity_error <= 1'b0;
      frame_error <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (ack) begin
        valid <= 1'b0;
        overrun <= 1'b0;
      end
      case (state)
        IDLE:
          if (!armed) armed <= rxd_s;
          else if (!rxd_s) begin
            state <= HALF == 0 ? DATA : START;
            cnt <= HALF == 0 ? RELOAD : HALF_M1;
            idx <= '0;
          end
        START:
          if (!sample) cnt <= cnt - W'(1);
          else if (rxd_s) state <= IDLE;
          else begin
            state <= DATA;
            cnt <= RELOAD;
            idx <= '0;
          end
        DATA:
          if (!sample) cnt <= cnt - W'(1);
          else begin
            shift[idx] <= rxd_s;
            cnt <= RELOAD;
            idx <= idx + 3'd1;
            if (idx == 3'd7) state <= PARITY;
          end
        PARITY:
          if (!sample) cnt <= cnt - W'(1);
          else begin
            par <= rxd_s;
            cnt <= RELOAD;
            state <= STOP;
          end
        STOP:
          if (!sample) cnt <= cnt - W'(1);
          else begin
            state <= IDLE;
            data_out <= shift;
            parity_error <= ~^{par, shift};
            frame_error <= ~rxd_s;
            valid <= 1'b1;
            overrun <= ~ack & (overrun | valid);
            if (!rxd_s) armed <= 1'b0;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb_uart_rx_deframer: randomized frame checks against a frame-level model at 1 and 16 clocks per bit
module tb_uart_rx_deframer;
  logic clock = 1'b0, reset = 1'b0;
  logic rxd1 = 1'b0, rxd16 = 1'b0, notify1 = 1'b0, notify16 = 1'b0;
  logic [7:0] data1, data16;
  logic valid1, pe1, fe1, ov1, valid16, pe16, fe16, ov16;
  logic [11:0] obs1, obs16;
  logic pv1 = 1'b0, pv16 = 1'b0;
  int cyc = 0, rises1 = 0, rises16 = 0, rise1 = 0, rise16 = 0;
  int tests = 0, fails = 0;

  uart_rx_deframer #(.CLKS_PER_BIT(1)) u1 (
    .clock(clock), .reset(reset), .rxd(rxd1), .notify(notify1), .data_out(data1),
    .valid(valid1), .parity_error(pe1), .frame_error(fe1), .overrun(ov1));
  uart_rx_deframer #(.CLKS_PER_BIT(16)) u16 (
    .clock(clock), .reset(reset), .rxd(rxd16), .notify(notify16), .data_out(data16),
    .valid(valid16), .parity_error(pe16), .frame_error(fe16), .overrun(ov16));

  assign obs1 = {valid1, pe1, fe1, ov1, data1};
  assign obs16 = {valid16, pe16, fe16, ov16, data16};

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) begin
    pv1 <= valid1;
    pv16 <= valid16;
    if (valid1 && !pv1) begin
      rises1 <= rises1 + 1;
      rise1 <= cyc;
    end
    if (valid16 && !pv16) begin
      rises16 <= rises16 + 1;
      rise16 <= cyc;
    end
  end

  // {valid, parity_error, frame_error, overrun, data} expected after a completed frame
  function automatic logic [11:0] expv(input logic v, input logic [7:0] d, input logic p,
                                       input logic s, input logic ov);
    return {v, (($countones(d) + int'(p)) % 2) == 0, ~s, ov, d};
  endfunction

  function automatic logic odd_bit(input logic [7:0] d);
    return ($countones(d) % 2) == 0;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic hold(input bit big, input logic v, input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
      if (big) rxd16 = v;
      else rxd1 = v;
    end
  endtask

  task automatic send(input bit big, input logic [7:0] d, input logic p, input logic s,
                      input int nat, input bit noisy, output int t0);
    logic [10:0] f;
    logic b;
    int cpb;
    f = {s, p, d, 1'b0};
    cpb = big ? 16 : 1;
    t0 = 0;
    for (int i = 0; i < 11; i++)
      for (int j = 0; j < cpb; j++) begin
        @(posedge clock);
        #1;
        if (i == 0 && j == 0) t0 = cyc;
        if (nat >= 0 && cyc - t0 == nat) notify1 = 1'b1;
        b = (noisy && i >= 1 && i <= 9 && (j < 4 || j >= 12)) ? 1'($urandom_range(0, 1)) : f[i];
        if (big) rxd16 = b;
        else rxd1 = b;
      end
  endtask

  task automatic ack_pulse(input bit big);
    @(posedge clock);
    #1;
    if (big) notify16 = 1'b1;
    else notify1 = 1'b1;
    tick(2);
    notify1 = 1'b0;
    notify16 = 1'b0;
    tick(4);
  endtask

  task automatic test_reset;
    tick(3);
    tests++;
    if (obs1 !== 12'h000) begin
      fails++;
      $display("FAIL reset_state_1: got %h want %h", obs1, 12'h000);
    end
    tests++;
    if (obs16 !== 12'h000) begin
      fails++;
      $display("FAIL reset_state_16: got %h want %h", obs16, 12'h000);
    end
    reset = 1'b1;
    tick(20);
    tests++;
    if (rises1 + rises16 !== 0) begin
      fails++;
      $display("FAIL low_line_not_start: got %0d valid events want 0", rises1 + rises16);
    end
    rxd1 = 1'b1;
    rxd16 = 1'b1;
    tick(5);
  endtask

  task automatic test_good_frame;
    int t0;
    send(0, 8'hA5, 1'b1, 1'b1, -1, 0, t0);
    hold(0, 1'b1, 4);
    tests++;
    if (obs1 !== expv(1, 8'hA5, 1, 1, 0)) begin
      fails++;
      $display("FAIL good_a5: got %h want %h", obs1, expv(1, 8'hA5, 1, 1, 0));
    end
    tests++;
    if (rise1 !== t0 + 13) begin
      fails++;
      $display("FAIL latency_1: got %0d want %0d", rise1 - t0, 13);
    end
    ack_pulse(0);
    tests++;
    if (valid1 !== 1'b0) begin
      fails++;
      $display("FAIL ack_clears_valid: got %b want 0", valid1);
    end
  endtask

  task automatic test_parity;
    int t0;
    send(0, 8'hA5, 1'b0, 1'b1, -1, 0, t0);
    hold(0, 1'b1, 4);
    tests++;
    if (obs1 !== expv(1, 8'hA5, 0, 1, 0)) begin
      fails++;
      $display("FAIL parity_bad: got %h want %h", obs1, expv(1, 8'hA5, 0, 1, 0));
    end
    ack_pulse(0);
    send(0, 8'h3C, 1'b1, 1'b1, -1, 0, t0);
    hold(0, 1'b1, 4);
    tests++;
    if (obs1 !== expv(1, 8'h3C, 1, 1, 0)) begin
      fails++;
      $display("FAIL parity_recover: got %h want %h", obs1, expv(1, 8'h3C, 1, 1, 0));
    end
    ack_pulse(0);
  endtask

  task automatic test_break;
    int t0, base;
    base = rises1;
    send(0, 8'h00, 1'b1, 1'b0, -1, 0, t0);
    hold(0, 1'b0, 20);
    tests++;
    if (obs1 !== expv(1, 8'h00, 1, 0, 0)) begin
      fails++;
      $display("FAIL break_frame: got %h want %h", obs1, expv(1, 8'h00, 1, 0, 0));
    end
    tests++;
    if (rises1 - base !== 1) begin
      fails++;
      $display("FAIL break_single_event: got %0d want 1", rises1 - base);
    end
    ack_pulse(0);
    hold(0, 1'b1, 4);
    send(0, 8'h81, 1'b1, 1'b1, -1, 0, t0);
    hold(0, 1'b1, 4);
    tests++;
    if (obs1 !== expv(1, 8'h81, 1, 1, 0)) begin
      fails++;
      $display("FAIL after_break: got %h want %h", obs1, expv(1, 8'h81, 1, 1, 0));
    end
    ack_pulse(0);
  endtask

  task automatic test_back_to_back;
    int t0, t1, base;
    logic [7:0] d;
    base = rises1;
    send(0, 8'h11, 1'b1, 1'b1, -1, 0, t0);
    send(0, 8'h22, 1'b1, 1'b1, -1, 0, t1);
    hold(0, 1'b1, 4);
    tests++;
    if (obs1 !== expv(1, 8'h22, 1, 1, 1)) begin
      fails++;
      $display("FAIL overrun_set: got %h want %h", obs1, expv(1, 8'h22, 1, 1, 1));
    end
    tests++;
    if (rises1 - base !== 1 || rise1 !== t0 + 13) begin
      fails++;
      $display("FAIL back_to_back_events: got %0d rises at +%0d want 1 at +13", rises1 - base, rise1 - t0);
    end
    d = 8'($urandom);
    send(0, d, odd_bit(d), 1'b1, 9, 0, t0);
    hold(0, 1'b1, 4);
    notify1 = 1'b0;
    tests++;
    if (obs1 !== expv(1, d, odd_bit(d), 1, 0)) begin
      fails++;
      $display("FAIL ack_vs_completion: got %h want %h", obs1, expv(1, d, odd_bit(d), 1, 0));
    end
    ack_pulse(0);
  endtask

  task automatic test_glitch16;
    int t0, base;
    logic [7:0] d;
    logic p;
    base = rises16;
    hold(1, 1'b0, 3);
    hold(1, 1'b1, 40);
    tests++;
    if (rises16 !== base || valid16 !== 1'b0) begin
      fails++;
      $display("FAIL glitch_rejected: got %0d events valid=%b want 0 events valid=0", rises16 - base, valid16);
    end
    send(1, 8'h5A, 1'b1, 1'b1, -1, 0, t0);
    hold(1, 1'b1, 2);
    tests++;
    if (obs16 !== expv(1, 8'h5A, 1, 1, 0)) begin
      fails++;
      $display("FAIL frame16_5a: got %h want %h", obs16, expv(1, 8'h5A, 1, 1, 0));
    end
    tests++;
    if (rise16 !== t0 + 170) begin
      fails++;
      $display("FAIL latency_16: got %0d want %0d", rise16 - t0, 170);
    end
    ack_pulse(1);
    for (int n = 0; n < 4; n++) begin
      d = 8'($urandom);
      p = odd_bit(d) ^ ($urandom_range(0, 3) == 0);
      send(1, d, p, 1'b1, -1, 1, t0);
      hold(1, 1'b1, 2);
      tests++;
      if (obs16 !== expv(1, d, p, 1, 0)) begin
        fails++;
        $display("FAIL noisy16_%0d: got %h want %h", n, obs16, expv(1, d, p, 1, 0));
      end
      ack_pulse(1);
    end
  endtask

  task automatic test_random;
    int t0;
    logic [7:0] d;
    logic p, s, ev, ov;
    ev = 1'b0;
    ov = 1'b0;
    for (int n = 0; n < 20; n++) begin
      d = 8'($urandom);
      p = odd_bit(d) ^ ($urandom_range(0, 3) == 0);
      s = $urandom_range(0, 3) != 0;
      send(0, d, p, s, -1, 0, t0);
      hold(0, 1'b1, 4);
      ov = ov | ev;
      ev = 1'b1;
      tests++;
      if (obs1 !== expv(ev, d, p, s, ov)) begin
        fails++;
        $display("FAIL random_%0d: got %h want %h", n, obs1, expv(ev, d, p, s, ov));
      end
      if ($urandom_range(0, 1) == 1) begin
        ack_pulse(0);
        ev = 1'b0;
        ov = 1'b0;
      end
    end
    ack_pulse(0);
  endtask

  task automatic test_reset_mid;
    int t0, base;
    logic [7:0] d;
    d = 8'($urandom);
    send(0, d, ~odd_bit(d), 1'b1, -1, 0, t0);
    hold(0, 1'b1, 4);
    tests++;
    if (obs1 !== expv(1, d, ~odd_bit(d), 1, 0)) begin
      fails++;
      $display("FAIL pre_reset_frame: got %h want %h", obs1, expv(1, d, ~odd_bit(d), 1, 0));
    end
    d = 8'($urandom);
    for (int i = 0; i < 6; i++) begin
      @(posedge clock);
      #1;
      rxd1 = i == 0 ? 1'b0 : d[i-1];
      if (i == 5) reset = 1'b0;
    end
    rxd1 = 1'b0;
    tick(2);
    tests++;
    if (obs1 !== 12'h000) begin
      fails++;
      $display("FAIL reset_mid_frame: got %h want %h", obs1, 12'h000);
    end
    base = rises1;
    reset = 1'b1;
    tick(20);
    tests++;
    if (rises1 !== base || valid1 !== 1'b0) begin
      fails++;
      $display("FAIL rearm_after_reset: got %0d events want 0", rises1 - base);
    end
    hold(0, 1'b1, 4);
    send(0, d, odd_bit(d), 1'b1, -1, 0, t0);
    hold(0, 1'b1, 4);
    tests++;
    if (obs1 !== expv(1, d, odd_bit(d), 1, 0)) begin
      fails++;
      $display("FAIL post_reset_frame: got %h want %h", obs1, expv(1, d, odd_bit(d), 1, 0));
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_parity();
    test_break();
    test_back_to_back();
    test_glitch16();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
